// File: rtl/adder_tree_csa_ctrl.sv
// adder_tree_csa_ctrl: time-multiplexed multi-operand adder.
// A single 3:2 carry-save stage folds I_DATA_N words from a valid/ready
// stream into a registered sum/carry pair. One carry-propagate add then
// resolves the pair, and the frame total is held on a valid/ready output.
// Optional build macro: ADDER_TREE_CSA_CTRL_SIGNED_EN selects two's-complement
// input words, sign-extended before the CSA. When it is undefined, words are
// zero-extended (unsigned).
`timescale 1ns/1ps
module adder_tree_csa_ctrl #(
  parameter int I_DATA_W = 3,
  parameter int I_DATA_N = 21,
  localparam int O_DATA_W = I_DATA_W + $clog2(I_DATA_N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [I_DATA_W-1:0] i_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [O_DATA_W-1:0] o_data
);

  localparam int CNT_W = $clog2(I_DATA_N);
  localparam int EXT_W = O_DATA_W - I_DATA_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(I_DATA_N - 1);

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUT     = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [O_DATA_W-1:0] sum_vec;
  logic [O_DATA_W-1:0] sum_nxt;
  logic [O_DATA_W-1:0] carry_vec;
  logic [O_DATA_W-1:0] carry_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [O_DATA_W-1:0] data_nxt;
  logic                valid_nxt;
  logic [O_DATA_W-1:0] x_ext;
  logic [O_DATA_W-1:0] maj;
  logic                accept;

  // Operand extension to result width (sign or zero, by build).
  always_comb begin
`ifdef ADDER_TREE_CSA_CTRL_SIGNED_EN
    x_ext = {{EXT_W{i_data[I_DATA_W-1]}}, i_data};
`else
    x_ext = {{EXT_W{1'b0}}, i_data};
`endif
  end

  // Input readiness comes only from state and reset, never from i_valid/i_ready.
  always_comb begin
    o_ready = (state == ST_ACCUM) && !rst;
  end

  // Shared 3:2 stage: majority of S, C, X forms the next carry before shifting.
  always_comb begin
    maj    = (sum_vec & carry_vec) | (sum_vec & x_ext) | (carry_vec & x_ext);
    accept = i_valid && o_ready;
  end

  // Next-state and datapath update for the accumulate/resolve/output sequence.
  always_comb begin
    state_nxt = state;
    sum_nxt   = sum_vec;
    carry_nxt = carry_vec;
    cnt_nxt   = cnt;
    data_nxt  = o_data;
    valid_nxt = o_valid;
    case (state)
      ST_ACCUM: begin
        if (accept) begin
          sum_nxt   = sum_vec ^ carry_vec ^ x_ext;
          // Carry out of the MSB is dropped; the result stays exact mod 2^O_DATA_W.
          carry_nxt = {maj[O_DATA_W-2:0], 1'b0};
          cnt_nxt   = cnt + CNT_W'(1);
          if (cnt == LAST_IDX) begin
            state_nxt = ST_RESOLVE;
          end else begin
            state_nxt = ST_ACCUM;
          end
        end else begin
          state_nxt = ST_ACCUM;
        end
      end
      ST_RESOLVE: begin
        data_nxt  = sum_vec + carry_vec;
        sum_nxt   = {O_DATA_W{1'b0}};
        carry_nxt = {O_DATA_W{1'b0}};
        cnt_nxt   = {CNT_W{1'b0}};
        valid_nxt = 1'b1;
        state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (i_ready) begin
          valid_nxt = 1'b0;
          state_nxt = ST_ACCUM;
        end else begin
          valid_nxt = 1'b1;
          state_nxt = ST_OUT;
        end
      end
      default: begin
        sum_nxt   = {O_DATA_W{1'b0}};
        carry_nxt = {O_DATA_W{1'b0}};
        cnt_nxt   = {CNT_W{1'b0}};
        valid_nxt = 1'b0;
        state_nxt = ST_ACCUM;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ACCUM;
      sum_vec   <= {O_DATA_W{1'b0}};
      carry_vec <= {O_DATA_W{1'b0}};
      cnt       <= {CNT_W{1'b0}};
      o_data    <= {O_DATA_W{1'b0}};
      o_valid   <= 1'b0;
    end else begin
      state     <= state_nxt;
      sum_vec   <= sum_nxt;
      carry_vec <= carry_nxt;
      cnt       <= cnt_nxt;
      o_data    <= data_nxt;
      o_valid   <= valid_nxt;
    end
  end

endmodule
